// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Write-back arbiter and busy-bit scoreboard for the single write port of the
// 32 x 64-bit register file.
//
// Two producers share the write port: the ALU and the load/memory unit.
// One write is granted per cycle with round-robin fairness. The winning
// request is registered onto wa/wd/regWrite, so the register file sees the
// write one cycle after the handshake.
//
// The scoreboard holds one busy bit per architectural register. Decode sets a
// bit when it issues an instruction that writes that register. A granted
// write-back clears the bit again. Decode reads the bits through two query
// ports to detect RAW hazards.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   alu_valid/wa/wd, ready    ALU write-back request and its accept
//   mem_valid/wa/wd, ready    load write-back request and its accept
//   set_en, set_wa            mark set_wa busy (decode issued a writer)
//   q_ra1/q_ra2 -> q_busy1/2  combinational busy-bit queries
//   wa, wd, regWrite          registered register-file write port
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_wa,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_wa,
  input  logic [XLEN-1:0] mem_wd,
  output logic            mem_ready,
  input  logic            set_en,
  input  logic [AW-1:0]   set_wa,
  input  logic [AW-1:0]   q_ra1,
  input  logic [AW-1:0]   q_ra2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic [AW-1:0]   wa,
  output logic [XLEN-1:0] wd,
  output logic            regWrite
);

  localparam int NREGS = 1 << AW;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  // The pointer names the requester that wins the next conflict:
  // 0 means the ALU, 1 means the load unit.
  logic [PW-1:0]    ptr_reg;
  logic [AW-1:0]    wa_reg;
  logic [XLEN-1:0]  wd_reg;
  logic             reg_write_reg;

  // Register 0 is hard-wired to zero, so it has no busy flop.
  logic [NREGS-1:1] busy_reg;
  logic [NREGS-1:1] busy_next;
  logic [NREGS-1:0] busy_vec;

  logic             alu_gnt;
  logic             mem_gnt;
  logic             any_gnt;
  logic [AW-1:0]    gnt_wa;
  logic [XLEN-1:0]  gnt_wd;

  // A requester wins when it is the only one valid, or when both are valid
  // and the pointer favours it. A grant never goes to a requester whose
  // valid is low.
  always_comb begin
    alu_gnt = alu_valid & (~mem_valid | (ptr_reg == '0));
    mem_gnt = mem_valid & (~alu_valid | (ptr_reg != '0));
    any_gnt = alu_gnt | mem_gnt;
    gnt_wa  = alu_gnt ? alu_wa : mem_wa;
    gnt_wd  = alu_gnt ? alu_wd : mem_wd;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg       <= '0;
      wa_reg        <= '0;
      wd_reg        <= '0;
      reg_write_reg <= 1'b0;
    end else begin
      if (any_gnt) begin
        // Hand priority to the requester that did not just win.
        ptr_reg <= alu_gnt ? PW'(1) : '0;
        wa_reg  <= gnt_wa;
        wd_reg  <= gnt_wd;
      end
      // A write to x0 is accepted and consumed, but it never reaches the
      // register file.
      reg_write_reg <= any_gnt && (gnt_wa != '0);
    end
  end

  // Busy-bit update. A set wins over a clear of the same register in the
  // same cycle: the set belongs to a newer producer that is still pending.
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      assign busy_next[gi] = (set_en && (set_wa == AW'(gi))) |
                             (busy_reg[gi] & ~(any_gnt && (gnt_wa == AW'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // The queries read the current bits only. A write granted in this cycle
  // is still shown as busy; the register file forwards that data itself.
  assign busy_vec = {busy_reg, 1'b0};
  assign q_busy1  = busy_vec[q_ra1];
  assign q_busy2  = busy_vec[q_ra2];

  assign wa       = wa_reg;
  assign wd       = wd_reg;
  assign regWrite = reg_write_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: a table of single-cycle vectors, directed
// sequences for the scoreboard, x0 and reset cases, and a randomized run
// compared against a queue-based reference model.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [63:0] alu_wd;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_wa;
  logic [63:0] mem_wd;
  logic        mem_ready;
  logic        set_en;
  logic [4:0]  set_wa;
  logic [4:0]  q_ra1;
  logic [4:0]  q_ra2;
  logic        q_busy1;
  logic        q_busy2;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        regWrite;

  int vec_count = 0;
  int err_count = 0;

  rf_wb_arbiter #(.NREQ(2), .XLEN(64), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .set_en(set_en), .set_wa(set_wa),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .wa(wa), .wd(wd), .regWrite(regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    set_en = 1'b0; set_wa = '0;
  endtask

  // One table row is one cycle: the inputs, the ready values before the
  // edge, and the write port after the edge.
  typedef struct packed {
    logic        av;
    logic [4:0]  awa;
    logic [63:0] awd;
    logic        mv;
    logic [4:0]  mwa;
    logic [63:0] mwd;
    logic        ear;
    logic        emr;
    logic        erw;
    logic        chk_addr;
    logic [4:0]  ewa;
    logic [63:0] ewd;
  } vec_t;

  vec_t tbl[13];

  // Reference model state for the random run.
  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } req_t;
  req_t      alu_q[$];
  req_t      mem_q[$];
  bit [31:0] m_busy;
  bit        alu_turn;

  initial begin
    idle();
    q_ra1 = '0; q_ra2 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_regwrite", regWrite, 0);
    chk("reset_wa", wa, 0);
    chk("reset_wd", wd, 0);
    chk("reset_qbusy1", q_busy1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    //           av awa  awd                     mv mwa  mwd                   ar mr rw ck wa  wd
    tbl[0]  = '{1'b0, 5'd0, 64'h0,               1'b0, 5'd0, 64'h0,               1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 64'h0};
    tbl[1]  = '{1'b1, 5'd5, 64'hDEAD,            1'b0, 5'd0, 64'h0,               1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'hDEAD};
    tbl[2]  = '{1'b0, 5'd0, 64'h0,               1'b0, 5'd0, 64'h0,               1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 64'hDEAD};
    tbl[3]  = '{1'b0, 5'd0, 64'h0,               1'b1, 5'd3, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 64'hFEDC_BA98_7654_3210};
    tbl[4]  = '{1'b1, 5'd1, 64'hA1,              1'b1, 5'd2, 64'hB2,              1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 64'hA1};
    tbl[5]  = '{1'b1, 5'd1, 64'hA1,              1'b1, 5'd2, 64'hB2,              1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 64'hB2};
    tbl[6]  = '{1'b1, 5'd1, 64'hA1,              1'b1, 5'd2, 64'hB2,              1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 64'hA1};
    tbl[7]  = '{1'b1, 5'd1, 64'hA1,              1'b1, 5'd2, 64'hB2,              1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 64'hB2};
    tbl[8]  = '{1'b1, 5'd0, 64'hFF,              1'b0, 5'd0, 64'h0,               1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0};
    tbl[9]  = '{1'b1, 5'd4, 64'h44,              1'b1, 5'd6, 64'h66,              1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 64'h66};
    tbl[10] = '{1'b1, 5'd4, 64'h44,              1'b1, 5'd9, 64'h99,              1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 64'h44};
    tbl[11] = '{1'b0, 5'd0, 64'h0,               1'b1, 5'd9, 64'h99,              1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 64'h99};
    tbl[12] = '{1'b0, 5'd0, 64'h0,               1'b0, 5'd0, 64'h0,               1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 64'h99};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      alu_valid = tbl[i].av; alu_wa = tbl[i].awa; alu_wd = tbl[i].awd;
      mem_valid = tbl[i].mv; mem_wa = tbl[i].mwa; mem_wd = tbl[i].mwd;
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].ear);
      chk($sformatf("tbl%0d_mem_ready", i), mem_ready, tbl[i].emr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_regwrite", i), regWrite, tbl[i].erw);
      if (tbl[i].chk_addr) begin
        chk($sformatf("tbl%0d_wa", i), wa, tbl[i].ewa);
        chk($sformatf("tbl%0d_wd", i), wd, tbl[i].ewd);
      end
      $display("table row %0d: ar=%0b mr=%0b regWrite=%0b wa=%0d wd=%h", i, alu_ready, mem_ready, regWrite, wa, wd);
    end

    // Scoreboard: set, clear by grant, and set winning over a same-cycle clear.
    @(negedge clk); idle(); set_en = 1'b1; set_wa = 5'd7; q_ra1 = 5'd7; q_ra2 = 5'd3;
    #1 chk("sb_before_set", q_busy1, 0);
    @(posedge clk); #1;
    chk("sb_set7", q_busy1, 1);
    chk("sb_other3", q_busy2, 0);
    @(negedge clk); idle(); mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 64'h77;
    #1;
    chk("sb_mem_ready", mem_ready, 1);
    chk("sb_no_same_cycle_clear", q_busy1, 1);
    @(posedge clk); #1;
    chk("sb_cleared7", q_busy1, 0);
    chk("sb_write7", wa, 7);
    @(negedge clk); idle(); set_en = 1'b1; set_wa = 5'd7; mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 64'h78;
    @(posedge clk); #1;
    chk("sb_set_wins", q_busy1, 1);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("sb_still_busy", q_busy1, 1);
    @(negedge clk); idle(); alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 64'h79;
    @(posedge clk); #1;
    chk("sb_alu_clear", q_busy1, 0);
    $display("scoreboard sequence done");

    // x0 is never marked busy.
    @(negedge clk); idle(); set_en = 1'b1; set_wa = 5'd0; q_ra2 = 5'd0;
    @(posedge clk); #1;
    chk("x0_not_busy", q_busy2, 0);
    $display("x0 set sequence done");

    // Reset in the middle of a cycle while a write is on the port.
    @(negedge clk); idle(); alu_valid = 1'b1; alu_wa = 5'd10; alu_wd = 64'hABC;
    set_en = 1'b1; set_wa = 5'd12;
    @(posedge clk); #1;
    chk("pre_reset_regwrite", regWrite, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_regwrite", regWrite, 0);
    chk("async_reset_wa", wa, 0);
    chk("async_reset_wd", wd, 0);
    idle();
    for (int r = 0; r < 32; r++) begin
      q_ra1 = 5'(r);
      #1 chk($sformatf("reset_busy%0d", r), q_busy1, 0);
    end
    @(negedge clk) rst = 1'b1;
    // The pointer favoured the load unit before reset; afterwards it is the ALU.
    alu_valid = 1'b1; alu_wa = 5'd1; mem_valid = 1'b1; mem_wa = 5'd2;
    #1;
    chk("post_reset_alu_first", alu_ready, 1);
    chk("post_reset_mem_waits", mem_ready, 0);
    $display("mid-cycle reset sequence done");

    // Randomized run against the reference model.
    @(negedge clk); idle(); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    alu_q.delete(); mem_q.delete();
    m_busy = '0;
    alu_turn = 1'b1;
    for (int c = 0; c < 400; c++) begin
      int     winner;
      req_t   g;
      logic   exp_rw;
      @(negedge clk);
      if (alu_q.size() == 0 && $urandom_range(0, 99) < 60)
        alu_q.push_back('{a: 5'($urandom_range(0, 31)), d: {$urandom, $urandom}});
      if (mem_q.size() == 0 && $urandom_range(0, 99) < 60)
        mem_q.push_back('{a: 5'($urandom_range(0, 31)), d: {$urandom, $urandom}});
      alu_valid = (alu_q.size() != 0);
      alu_wa    = alu_valid ? alu_q[0].a : 5'd0;
      alu_wd    = alu_valid ? alu_q[0].d : 64'd0;
      mem_valid = (mem_q.size() != 0);
      mem_wa    = mem_valid ? mem_q[0].a : 5'd0;
      mem_wd    = mem_valid ? mem_q[0].d : 64'd0;
      set_en    = ($urandom_range(0, 3) == 0);
      set_wa    = 5'($urandom_range(0, 31));
      q_ra1     = 5'($urandom_range(0, 31));
      q_ra2     = 5'($urandom_range(0, 31));
      // Winner: 0 = ALU, 1 = load unit, -1 = nobody.
      if (alu_valid && mem_valid) winner = alu_turn ? 0 : 1;
      else if (alu_valid)         winner = 0;
      else if (mem_valid)         winner = 1;
      else                        winner = -1;
      #1;
      chk("rnd_alu_ready", alu_ready, winner == 0);
      chk("rnd_mem_ready", mem_ready, winner == 1);
      chk("rnd_q_busy1", q_busy1, m_busy[q_ra1]);
      chk("rnd_q_busy2", q_busy2, m_busy[q_ra2]);
      exp_rw = 1'b0;
      g = '0;
      if (winner == 0) g = alu_q.pop_front();
      if (winner == 1) g = mem_q.pop_front();
      if (winner >= 0) begin
        exp_rw   = (g.a != 0);
        alu_turn = (winner == 1);
        m_busy[g.a] = 1'b0;
      end
      if (set_en) m_busy[set_wa] = 1'b1;
      m_busy[0] = 1'b0;
      @(posedge clk); #1;
      chk("rnd_regwrite", regWrite, exp_rw);
      if (exp_rw) begin
        chk("rnd_wa", wa, g.a);
        chk("rnd_wd", wd, g.d);
      end
      $display("rnd cycle %0d: winner=%0d regWrite=%0b wa=%0d wd=%h", c, winner, regWrite, wa, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 32x64 register file's single write port.
- Two producers compete for that port: requester 0 is the ALU and requester 1 is the load/memory unit.
- Grants one write per cycle with round-robin fairness and drives registered wa/wd/regWrite into the register file.
- Tracks a per-register busy bit so that decode can detect RAW hazards on pending writes.

Parameters:
- NREQ, 2, number of write-back requesters (fixed at 2 in this revision).
- XLEN, 64, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU write-back request.
- alu_wa  input  AW  ALU destination register.
- alu_wd  input  XLEN  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- mem_valid  input  1  load write-back request.
- mem_wa  input  AW  load destination register.
- mem_wd  input  XLEN  load data.
- mem_ready  output  1  load request accepted this cycle.
- set_en  input  1  decode issued an instruction that writes set_wa.
- set_wa  input  AW  destination register to mark busy.
- q_ra1  input  AW  hazard query address 1.
- q_ra2  input  AW  hazard query address 2.
- q_busy1  output  1  busy[q_ra1].
- q_busy2  output  1  busy[q_ra2].
- wa  output  AW  register-file write address.
- wd  output  XLEN  register-file write data.
- regWrite  output  1  register-file write enable.

Behaviour:
- Reset (rst=0, asynchronous):
  - wa=0, wd=0, regWrite=0.
  - All 32 busy bits cleared.
  - Round-robin pointer set to 0, so the ALU has priority on the first conflict.
- Handshake:
  - A requester holds valid, wa and wd stable until its ready=1.
  - Transfer occurs on the edge where valid&ready=1.
  - ready is combinational from the valid inputs and the pointer.
  - ready is never 1 while valid=0.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: the requester selected by the pointer is granted.
  - After any grant, the pointer moves to the other requester; with no grant the pointer holds.
  - Under continuous contention, grants strictly alternate.
- Output timing:
  - 1-cycle latency. On a grant edge, regWrite<=1, wa<=granted wa, wd<=granted wd.
  - With no grant, regWrite<=0, and wa/wd hold their last values.
- x0 handling:
  - A granted request with wa=0 is accepted (ready=1) but regWrite<=0.
  - busy[0] is constantly 0; set_en with set_wa=0 is ignored.
- Scoreboard:
  - set_en=1 sets busy[set_wa] at the edge.
  - A grant clears busy[granted wa] at the edge.
  - Set and clear of the same register in the same cycle: the set wins, because a newer producer is pending.
- Query outputs:
  - q_busy1/q_busy2 are combinational reads of the current busy bits.
  - They do not reflect the same-cycle grant; the register file forwards same-cycle data via its combinational read.
- Both requesters targeting the same register in one cycle: only one is granted; the other writes in a later cycle.
  - Final register value follows grant order; decode must prevent this case through the scoreboard.
- Reset mid-transfer: any un-granted request is discarded. Requesters must re-present after reset deasserts.
- Width rules: no arithmetic on data; wd is passed through unchanged at XLEN.

Test Plan:
- Reset: assert rst=0 mid-cycle with regWrite high -> regWrite, wa, wd drop to 0 immediately; all q_busy=0.
- Single ALU write: alu_valid=1, alu_wa=5, alu_wd=0xDEAD -> alu_ready=1 same cycle; next cycle regWrite=1, wa=5, wd=0xDEAD; then regWrite=0.
- Contention: both valid for 4 cycles (alu_wa=1, mem_wa=2), each re-presenting after acceptance -> grant order ALU, MEM, ALU, MEM; wa sequence 1, 2, 1, 2 with regWrite=1 every cycle.
- Scoreboard: set_en=1, set_wa=7 -> q_busy1=1 when q_ra1=7; mem write to 7 granted -> q_busy1=0 the following cycle. Same cycle, set_en=1 set_wa=7 plus grant to 7 -> busy[7] stays 1.
- x0: alu_valid=1, alu_wa=0, alu_wd=0xFF -> alu_ready=1, regWrite stays 0; set_en=1, set_wa=0 -> q_busy for 0 stays 0.
- Hold: mem_valid=1 while losing arbitration -> mem_ready=0 and mem_wa/mem_wd held; next cycle mem_ready=1 and the write is presented with the held values.
